// File: rtl/weight_seq_pkg.sv
// Shared types and default geometry for the weight memory sequencer.
package weight_seq_pkg;

  localparam int unsigned LAYER_SIZE_DEF  = 4;
  localparam int unsigned LAYER_DEPTH_DEF = 4;
  localparam int unsigned BIT_SIZE_DEF    = 16;

  // Address field widths for the default geometry.
  localparam int unsigned LW = $clog2(LAYER_DEPTH_DEF);
  localparam int unsigned NW = $clog2(LAYER_SIZE_DEF);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StFlush
  } state_e;

endpackage

// File: rtl/nested_addr_counter.sv
// Layer / outer / inner address counter. Inner counts fastest; the optional outer level
// sits between inner and layer. `last` flags the final position for the programmed layer
// count, and stepping past it wraps every level back to zero.
module nested_addr_counter #(
  parameter int unsigned LW        = 2,
  parameter int unsigned NW        = 2,
  parameter bit          HAS_OUTER = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [LW:0]   layer_limit,
  output logic [LW-1:0] layer,
  output logic [NW-1:0] outer,
  output logic [NW-1:0] inner,
  output logic          last
);

  logic inner_wrap;
  logic outer_wrap;

  assign inner_wrap = &inner;
  assign outer_wrap = HAS_OUTER ? (&outer) : 1'b1;
  assign last       = inner_wrap && outer_wrap &&
                      ({1'b0, layer} == (layer_limit - (LW+1)'(1)));

  // Counter state: clear wins over enable; levels carry on wrap of the level below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer <= '0;
      outer <= '0;
      inner <= '0;
    end else if (clr) begin
      layer <= '0;
      outer <= '0;
      inner <= '0;
    end else if (en) begin
      inner <= inner + 1'b1;
      if (HAS_OUTER && inner_wrap) outer <= outer + 1'b1;
      if (inner_wrap && outer_wrap) layer <= last ? '0 : layer + 1'b1;
    end
  end

endmodule

// File: rtl/weight_mem_sequencer.sv
// Weight memory sequencer: turns a valid/ready weight stream into banked writes (LOAD) and
// sweeps one full column per cycle out of the memory for the MAC array (RUN). The memory
// read is expected to be qualified by run_stall so its output holds while stalled.
module weight_mem_sequencer
  import weight_seq_pkg::*;
#(
  parameter int unsigned LAYER_SIZE  = LAYER_SIZE_DEF,
  parameter int unsigned LAYER_DEPTH = LAYER_DEPTH_DEF,
  parameter int unsigned BIT_SIZE    = BIT_SIZE_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [$clog2(LAYER_DEPTH):0]   num_layers,
  input  logic                           load_start,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [BIT_SIZE-1:0]            load_data,
  input  logic                           run_start,
  input  logic                           run_stall,
  output logic                           mem_we,
  output logic [$clog2(LAYER_DEPTH)-1:0] mem_wr_layer,
  output logic [$clog2(LAYER_SIZE)-1:0]  mem_wr_node,
  output logic [$clog2(LAYER_SIZE)-1:0]  mem_wr_bank,
  output logic [BIT_SIZE-1:0]            mem_wr_data,
  output logic [$clog2(LAYER_DEPTH)-1:0] mem_rd_layer,
  output logic [$clog2(LAYER_SIZE)-1:0]  mem_rd_node,
  output logic                           w_valid,
  output logic [$clog2(LAYER_DEPTH)-1:0] w_layer,
  output logic [$clog2(LAYER_SIZE)-1:0]  w_node,
  output logic                           w_last,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int unsigned LAYER_W = $clog2(LAYER_DEPTH);
  localparam int unsigned NODE_W  = $clog2(LAYER_SIZE);

  state_e               state_q, state_d;
  logic [LAYER_W:0]     num_q, num_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic                 w_valid_q, w_valid_d;
  logic                 w_last_q, w_last_d;
  logic [LAYER_W-1:0]   w_layer_q, w_layer_d;
  logic [NODE_W-1:0]    w_node_q, w_node_d;

  logic                 legal;
  logic                 ld_clr, ld_en, ld_last;
  logic [LAYER_W-1:0]   ld_layer;
  logic [NODE_W-1:0]    ld_bank, ld_node;
  logic                 rd_clr, rd_en, rd_last;
  logic [LAYER_W-1:0]   rd_layer;
  logic [NODE_W-1:0]    rd_node;
  logic [NODE_W-1:0]    unused_rd_outer;

  assign legal = (num_layers != '0) && (num_layers <= (LAYER_W+1)'(LAYER_DEPTH));

  nested_addr_counter #(
    .LW        (LAYER_W),
    .NW        (NODE_W),
    .HAS_OUTER (1'b1)
  ) u_load_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (ld_clr),
    .en          (ld_en),
    .layer_limit (num_q),
    .layer       (ld_layer),
    .outer       (ld_bank),
    .inner       (ld_node),
    .last        (ld_last)
  );

  nested_addr_counter #(
    .LW        (LAYER_W),
    .NW        (NODE_W),
    .HAS_OUTER (1'b0)
  ) u_run_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (rd_clr),
    .en          (rd_en),
    .layer_limit (num_q),
    .layer       (rd_layer),
    .outer       (unused_rd_outer),
    .inner       (rd_node),
    .last        (rd_last)
  );

  // Next-state, counter control, write strobes and tag pipeline updates.
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    err_d       = err_q;
    done_d      = 1'b0;
    w_valid_d   = w_valid_q;
    w_layer_d   = w_layer_q;
    w_node_d    = w_node_q;
    w_last_d    = w_last_q;
    ld_clr      = 1'b0;
    ld_en       = 1'b0;
    rd_clr      = 1'b0;
    rd_en       = 1'b0;
    load_ready  = 1'b0;
    mem_we      = 1'b0;
    mem_wr_data = '0;
    unique case (state_q)
      StIdle: begin
        w_valid_d = 1'b0;
        w_last_d  = 1'b0;
        if (load_start || run_start) begin
          if (legal) begin
            err_d = 1'b0;
            num_d = num_layers;
            if (load_start) begin
              state_d = StLoad;
              ld_clr  = 1'b1;
            end else begin
              state_d = StRun;
              rd_clr  = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        load_ready  = 1'b1;
        ld_en       = load_valid;
        mem_we      = load_valid;
        mem_wr_data = load_data;
        if (load_valid && ld_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StRun: begin
        if (!run_stall) begin
          rd_en     = 1'b1;
          w_valid_d = 1'b1;
          w_layer_d = rd_layer;
          w_node_d  = rd_node;
          w_last_d  = rd_last;
          if (rd_last) state_d = StFlush;
        end
      end
      StFlush: begin
        // The final column is on the bus now; retire it on the first unstalled cycle.
        if (!run_stall) begin
          w_valid_d = 1'b0;
          w_last_d  = 1'b0;
          state_d   = StIdle;
          done_d    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if ((state_q != StIdle) && (load_start || run_start)) err_d = 1'b1;
  end

  // State, status and tag pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      num_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      w_valid_q <= 1'b0;
      w_layer_q <= '0;
      w_node_q  <= '0;
      w_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      err_q     <= err_d;
      done_q    <= done_d;
      w_valid_q <= w_valid_d;
      w_layer_q <= w_layer_d;
      w_node_q  <= w_node_d;
      w_last_q  <= w_last_d;
    end
  end

  assign mem_wr_layer = ld_layer;
  assign mem_wr_bank  = ld_bank;
  assign mem_wr_node  = ld_node;
  assign mem_rd_layer = rd_layer;
  assign mem_rd_node  = rd_node;
  assign w_valid      = w_valid_q;
  assign w_layer      = w_layer_q;
  assign w_node       = w_node_q;
  assign w_last       = w_last_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_weight_mem_sequencer.sv
// Self-checking bench for weight_mem_sequencer with a behavioural banked memory and a
// column-stream reference model.
module tb_weight_mem_sequencer;
  import weight_seq_pkg::*;

  localparam int LS = LAYER_SIZE_DEF;
  localparam int LD = LAYER_DEPTH_DEF;
  localparam int BS = BIT_SIZE_DEF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [LW:0]   num_layers;
  logic          load_start, load_valid, load_ready;
  logic [BS-1:0] load_data;
  logic          run_start, run_stall;
  logic          mem_we;
  logic [LW-1:0] mem_wr_layer, mem_rd_layer, w_layer;
  logic [NW-1:0] mem_wr_node, mem_wr_bank, mem_rd_node, w_node;
  logic [BS-1:0] mem_wr_data;
  logic          w_valid, w_last, busy, done, err;

  weight_mem_sequencer #(
    .LAYER_SIZE  (LS),
    .LAYER_DEPTH (LD),
    .BIT_SIZE    (BS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .num_layers   (num_layers),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .run_start    (run_start),
    .run_stall    (run_stall),
    .mem_we       (mem_we),
    .mem_wr_layer (mem_wr_layer),
    .mem_wr_node  (mem_wr_node),
    .mem_wr_bank  (mem_wr_bank),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_layer (mem_rd_layer),
    .mem_rd_node  (mem_rd_node),
    .w_valid      (w_valid),
    .w_layer      (w_layer),
    .w_node       (w_node),
    .w_last       (w_last),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int we_bad = 0;

  typedef struct {
    int layer;
    int bank;
    int node;
    int data;
  } wr_t;

  wr_t           wlog[$];
  logic [BS-1:0] mem [LD][LS][LS];
  logic [BS-1:0] rd_bus [LS];
  logic [BS-1:0] words [LD*LS*LS];
  logic [BS-1:0] model_mem [LD*LS*LS];

  // Banked memory: registered read held while stalled, writes logged for checking.
  always @(posedge clk) begin
    if (!run_stall) begin
      for (int j = 0; j < LS; j++) rd_bus[j] <= mem[mem_rd_layer][j][mem_rd_node];
    end
    if (mem_we) begin
      mem[mem_wr_layer][mem_wr_bank][mem_wr_node] <= mem_wr_data;
      wlog.push_back('{int'(mem_wr_layer), int'(mem_wr_bank), int'(mem_wr_node),
                       int'(mem_wr_data)});
      if (!load_valid || !load_ready) we_bad++;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drives a full LOAD of n layers from words[]; mode 0 back-to-back, 1 alternate, 2 random.
  task automatic load_seq(input int n, input int mode);
    int  total = n * LS * LS;
    int  w = 0;
    int  s = 0;
    bit  v;
    bit  seen = 1'b0;
    wlog.delete();
    num_layers = (LW+1)'(n);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check("load_busy", busy, 1);
    check("load_err_clear", err, 0);
    while (s < 500) begin
      if (w == total) begin
        check("load_done_pulse", done, 1);
        seen = 1'b1;
        break;
      end
      if (done) check("load_early_done", done, 0);
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (s % 2 == 0);
      else                v = ($urandom_range(0, 2) != 0);
      load_valid = v;
      load_data  = v ? words[w] : BS'($urandom);
      #1;
      check("load_ready", load_ready, 1);
      check("load_mem_we", mem_we, v);
      if (v) w++;
      @(negedge clk);
      s++;
    end
    load_valid = 1'b0;
    if (!seen) check("load_timeout", 0, 1);
    if (mode == 0) check("load_cycles_b2b", s, total);
    if (mode == 1) check("load_cycles_alt", s, 2 * total - 1);
    check("load_idle_after", busy, 0);
    check("load_write_count", wlog.size(), total);
    for (int i = 0; i < wlog.size() && i < total; i++) begin
      check("wr_layer", wlog[i].layer, i / (LS * LS));
      check("wr_bank", wlog[i].bank, (i / LS) % LS);
      check("wr_node", wlog[i].node, i % LS);
      check("wr_data", wlog[i].data, words[i]);
    end
    for (int i = 0; i < total; i++) model_mem[i] = words[i];
    @(negedge clk);
    check("load_done_one_cycle", done, 0);
  endtask

  // Runs n layers; mode 0 no stall, 1 stall 3 cycles at tag (0,2), 2 random stalls.
  // inject >= 0 pulses load_start on that cycle of the run.
  task automatic run_seq(input int n, input int mode, input int inject, input bit chk25);
    int            total = n * LS;
    int            idx = 0;
    int            vcnt = 0;
    int            stall_left = 3;
    int            el, ek;
    bit            stall;
    bit            pst = 1'b0;
    bit            ok = 1'b0;
    logic          pv;
    logic [LW-1:0] pl;
    logic [NW-1:0] pn;
    logic [BS-1:0] pd [LS];
    num_layers = (LW+1)'(n);
    run_start  = 1'b1;
    @(negedge clk);
    run_start = 1'b0;
    check("run_busy", busy, 1);
    check("run_err_clear", err, 0);
    for (int s = 0; s < 500; s++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (pst) begin
        check("stall_hold_valid", w_valid, pv);
        if (pv) begin
          check("stall_hold_layer", w_layer, pl);
          check("stall_hold_node", w_node, pn);
          for (int j = 0; j < LS; j++) check("stall_hold_data", rd_bus[j], pd[j]);
        end
      end
      if (inject >= 0 && s == inject + 1) begin
        check("busy_start_err", err, 1);
        check("busy_start_still_busy", busy, 1);
        check("busy_start_no_load", load_ready, 0);
      end
      if (mode == 0) begin
        stall = 1'b0;
      end else if (mode == 1) begin
        stall = w_valid && (w_layer == 0) && (w_node == 2) && (stall_left > 0);
        if (stall) stall_left--;
      end else begin
        stall = ($urandom_range(0, 3) == 0);
      end
      run_stall  = stall;
      load_start = (s == inject);
      if (s == inject) num_layers = (LW+1)'(1);
      check("run_no_we", mem_we, 0);
      if (w_valid) vcnt++;
      if (w_valid && !stall) begin
        if (idx >= total) begin
          check("run_extra_column", idx, total - 1);
        end else begin
          el = idx / LS;
          ek = idx % LS;
          check("col_layer", w_layer, el);
          check("col_node", w_node, ek);
          check("col_last", w_last, (idx == total - 1));
          for (int j = 0; j < LS; j++) check("col_data", rd_bus[j], model_mem[el*LS*LS + j*LS + ek]);
          if (chk25 && el == 1 && ek == 1) check("bank2_at_1_1", rd_bus[2], 25);
        end
        idx++;
      end
      pst = stall;
      pv  = w_valid;
      pl  = w_layer;
      pn  = w_node;
      pd  = rd_bus;
      @(negedge clk);
      load_start = 1'b0;
    end
    run_stall = 1'b0;
    if (!ok) check("run_timeout", 0, 1);
    check("run_column_count", idx, total);
    check("run_done_valid_low", w_valid, 0);
    check("run_done_idle", busy, 0);
    if (mode == 0) check("run_valid_cycles", vcnt, total);
    @(negedge clk);
    check("run_done_one_cycle", done, 0);
  endtask

  typedef struct {
    bit ld;
    bit rn;
    int num;
    bit exp_err;
    bit exp_busy;
    bit exp_ready;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    num_layers = '0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    run_start  = 1'b0;
    run_stall  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_done", done, 0);
    check("rst_w_valid", w_valid, 0);
    check("rst_w_last", w_last, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_rd_layer", mem_rd_layer, 0);
    check("rst_rd_node", mem_rd_node, 0);
    check("rst_wr_addr", {mem_wr_layer, mem_wr_bank, mem_wr_node}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Start-legality vectors applied from IDLE; busy outcomes are cleared with a reset.
    vecs[0] = '{0, 1, 0, 1, 0, 0};
    vecs[1] = '{1, 0, 0, 1, 0, 0};
    vecs[2] = '{1, 0, 5, 1, 0, 0};
    vecs[3] = '{0, 1, 7, 1, 0, 0};
    vecs[4] = '{1, 0, 4, 0, 1, 1};
    vecs[5] = '{0, 1, 0, 1, 0, 0};
    vecs[6] = '{0, 1, 1, 0, 1, 0};
    vecs[7] = '{1, 1, 3, 0, 1, 1};
    vecs[8] = '{1, 0, 5, 1, 0, 0};
    vecs[9] = '{1, 1, 0, 1, 0, 0};
    for (int i = 0; i < 10; i++) begin
      num_layers = (LW+1)'(vecs[i].num);
      load_start = vecs[i].ld;
      run_start  = vecs[i].rn;
      @(negedge clk);
      load_start = 1'b0;
      run_start  = 1'b0;
      check("vec_err", err, vecs[i].exp_err);
      check("vec_busy", busy, vecs[i].exp_busy);
      check("vec_ready", load_ready, vecs[i].exp_ready);
      if (vecs[i].exp_busy) begin
        rst_n = 1'b0;
        #1;
        check("vec_rst_busy", busy, 0);
        check("vec_rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
      end
    end

    for (int i = 0; i < LD*LS*LS; i++) words[i] = BS'(i);
    load_seq(2, 0);
    if (wlog.size() == 32) begin
      check("word5_addr", {wlog[5].layer, wlog[5].bank, wlog[5].node}, {32'd0, 32'd1, 32'd1});
      check("word31_addr", {wlog[31].layer, wlog[31].bank, wlog[31].node},
            {32'd1, 32'd3, 32'd3});
    end
    load_seq(2, 1);
    run_seq(2, 0, -1, 1'b1);
    run_seq(2, 1, -1, 1'b0);
    run_seq(2, 0, 3, 1'b0);

    // Asynchronous reset in the middle of a run.
    num_layers = (LW+1)'(4);
    run_start  = 1'b1;
    @(negedge clk);
    run_start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_valid", w_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", w_valid, 0);
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", w_valid, 0);
    @(negedge clk);
    run_seq(2, 0, -1, 1'b0);

    for (int it = 0; it < 6; it++) begin
      int n;
      n = $urandom_range(1, LD);
      for (int i = 0; i < LD*LS*LS; i++) words[i] = BS'($urandom);
      load_seq(n, 2);
      run_seq(n, 2, -1, 1'b0);
    end

    check("we_outside_valid_load", we_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
